imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory that the core's fetch/decode path reads.
//  Takes a byte stream from the UART receiver, frames it into 32-bit instruction words,
//  and writes them to imem. Holds the core in reset while a load is in progress.
//  Releases the core once a complete, valid image is in memory.
// PARAMETERS
//  ADDR_W  8      imem word-address width; capacity = 2**ADDR_W words
//  MAGIC   8'hA5  frame start byte
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  rx_data      in   8       received byte from UART receiver
//  rx_valid     in   1       1-cycle strobe: rx_data valid
//  imem_we      out  1       imem write enable (1-cycle pulse per word)
//  imem_addr    out  ADDR_W  imem word address
//  imem_wdata   out  32      instruction word
//  cpu_reset    out  1       hold core in reset (active-high)
//  load_done    out  1       image loaded OK (level)
//  load_err     out  1       frame error (level)
//  words_loaded out  16      words written in current/last load
// BEHAVIOUR
//  Frame: MAGIC, LEN_lo, LEN_hi (word count N, 16b LE), N x 4 data bytes (LE), [CSUM].
//  Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0,
//   load_err=0, words_loaded=0, state=IDLE. rx_valid in a reset cycle is ignored.
//  All state advances only on cycles with rx_valid=1.
//  States:
//  - IDLE: MAGIC -> LEN0; clear words_loaded and byte index. Any other byte is dropped.
//  - LEN0: latch LEN_lo -> LEN1.
//  - LEN1: latch LEN_hi, then branch:
//     N > 2**ADDR_W -> ERR; N==0 -> CSUM if macro defined, else DONE; otherwise -> DATA.
//  - DATA: shift bytes into word buffer; byte k goes to bits [8k+7:8k].
//     On byte 3: next cycle imem_we=1, imem_wdata=word, imem_addr=word index;
//     words_loaded increments in that same cycle.
//     After word N-1 -> CSUM if macro defined, else DONE.
//  - DONE: cpu_reset=0, load_done=1. Byte MAGIC -> LEN0 (re-program):
//     cpu_reset=1 and load_done=0 on the next cycle.
//  - ERR: load_err=1, cpu_reset=1. Byte MAGIC -> LEN0; load_err clears.
//  Latency: imem_we is 1 cycle after the rx_valid carrying byte 3 of each word.
//   cpu_reset deasserts 1 cycle after the final accepted byte.
//  imem_addr range: 0..N-1; no wrap, because N is bounded by the LEN1 check.
//   N == 2**ADDR_W is legal and fills memory exactly.
//  Back-to-back rx_valid on consecutive cycles: every byte is accepted, no stalls.
//  Reset mid-load: returns to IDLE with cpu_reset=1. imem contents are left undefined
//   (partially written).
//  load_done and load_err are never both 1.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - Frame ends with a CSUM byte = XOR of LEN_lo, LEN_hi and all data bytes.
//   - Match -> DONE; mismatch -> ERR.
//   - Words are already written to imem before the check; on mismatch the core stays
//     in reset.
//  Not defined:
//   - No CSUM byte; last data byte -> DONE.
//   - No XOR register is synthesised.
// TESTING
//  1. Reset -> cpu_reset=1, load_done=0, load_err=0, imem_we=0, words_loaded=0.
//  2. Stream A5 02 00 13 00 00 00 93 00 10 00 -> imem[0]=32'h00000013,
//     imem[1]=32'h00100093, exactly two imem_we pulses, words_loaded=2;
//     then load_done=1 and cpu_reset=0.
//  3. Junk 00 FF then A5 01 00 + 4 bytes -> junk ignored, 1 word at addr 0, DONE.
//  4. ADDR_W=8: A5 01 01 (N=257) -> load_err=1 with no imem_we.
//     A5 00 01 (N=256) -> accepted; last write at imem_addr=8'hFF.
//  5. reset asserted after 2 data bytes -> IDLE, cpu_reset=1.
//     A subsequent full frame loads correctly from addr 0.
//  6. With IMEM_LOADER_CHECKSUM_EN: A5 01 00 13 00 00 00 CSUM=0x12 -> DONE.
//     Same frame with CSUM=0x00 -> load_err=1, cpu_reset=1.
//     Then a fresh A5 frame clears load_err.

Source files
------------

// File: rtl/imem_loader.sv
// Frames a UART byte stream (MAGIC, LEN, data words, optional CSUM) into imem writes and
// holds the core in reset until a valid image is loaded. Checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_reset,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [15:0]       o_words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e EndState = StCsum;
`else
    localparam state_e EndState = StDone;
`endif

    state_e              r_state;
    state_e              w_state_next;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_buf;
    logic [15:0]         r_words;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic [15:0] w_len;
    logic        w_last_word;
    logic        w_magic;

    assign w_len       = {i_rx_data, r_len_lo};
    assign w_last_word = (r_words + 16'd1) == r_len;
    assign w_magic     = i_rx_data == MAGIC;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_rx_valid) begin
            unique case (r_state)
                StIdle, StDone, StErr: begin
                    if (w_magic) begin
                        w_state_next = StLen0;
                    end
                end
                StLen0: w_state_next = StLen1;
                StLen1: begin
                    if ({1'b0, w_len} > MaxWords) begin
                        w_state_next = StErr;
                    end else if (w_len == 16'd0) begin
                        w_state_next = EndState;
                    end else begin
                        w_state_next = StData;
                    end
                end
                StData: begin
                    if (r_byte_idx == 2'd3 && w_last_word) begin
                        w_state_next = EndState;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StCsum: w_state_next = (i_rx_data == r_csum) ? StDone : StErr;
`endif
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Status is a pure decode of the state, so done and err can never overlap.
    assign o_cpu_reset    = r_state != StDone;
    assign o_load_done    = r_state == StDone;
    assign o_load_err     = r_state == StErr;
    assign o_imem_we      = r_we;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = r_wdata;
    assign o_words_loaded = r_words;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_byte_idx <= 2'd0;
            r_buf      <= 24'd0;
            r_words    <= 16'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            if (i_rx_valid) begin
                unique case (r_state)
                    StIdle, StDone, StErr: begin
                        if (w_magic) begin
                            r_words    <= 16'd0;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    StLen0: begin
                        r_len_lo <= i_rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum   <= i_rx_data;
`endif
                    end
                    StLen1: begin
                        r_len <= w_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ i_rx_data;
`endif
                    end
                    StData: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_rx_data;
`endif
                        unique case (r_byte_idx)
                            2'd0: r_buf[7:0]   <= i_rx_data;
                            2'd1: r_buf[15:8]  <= i_rx_data;
                            2'd2: r_buf[23:16] <= i_rx_data;
                            2'd3: begin
                                r_we    <= 1'b1;
                                r_wdata <= {i_rx_data, r_buf};
                                r_addr  <= r_words[ADDR_W-1:0];
                                r_words <= r_words + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level model predicts every imem write and the
// final status of each frame; table vectors, hand-written corner cases and random frames.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [15:0]       words_loaded;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .MAGIC  (8'hA5)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_reset    (cpu_reset),
        .o_load_done    (load_done),
        .o_load_err     (load_err),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t         exp_q[$];
    logic [31:0] preset[$];

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          junk;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Every write the DUT makes must be the next one the model predicted.
    wr_t mon_e;
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("write_data", imem_wdata, mon_e.data);
                check("words_at_write", 32'(words_loaded), 32'(mon_e.addr) + 1);
            end
        end
        if (load_done === 1'b1 && load_err === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_err_exclusive: got both 1, expected at most one");
        end
    end

    // Called at a negedge; returns at the negedge after the byte's accepting edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_junk(input int cnt);
        logic [7:0] j;
        for (int i = 0; i < cnt; i++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h00;
            send(j);
        end
    endtask

    // Builds a frame of n words (preset words first, then random), predicts the writes,
    // streams it and checks imem_we and cpu_reset latency.
    task automatic run_frame(input int n, input bit bad_csum, input int gap_max);
        logic [7:0]  bytes[$];
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        bit          ok;
        int          wpos[$];
        logic [15:0] len;
        len = 16'(n);
        bytes.push_back(8'hA5);
        bytes.push_back(len[7:0]);
        bytes.push_back(len[15:8]);
        cs = len[7:0] ^ len[15:8];
        ok = n <= 256;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w = (preset.size() != 0) ? preset.pop_front() : $urandom;
                for (int k = 0; k < 4; k++) begin
                    bytes.push_back(w[8*k +: 8]);
                    cs ^= w[8*k +: 8];
                end
                wpos.push_back(bytes.size() - 1);
                e.addr = ADDR_W'(i);
                e.data = w;
                exp_q.push_back(e);
            end
            if (CsumEn) begin
                bytes.push_back(bad_csum ? ~cs : cs);
                ok = !bad_csum;
            end
        end
        for (int i = 0; i < bytes.size(); i++) begin
            send(bytes[i]);
            if (wpos.size() != 0 && wpos[0] == i) begin
                void'(wpos.pop_front());
                check("we_latency", 32'(imem_we), 32'd1);
            end
            if (i != bytes.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        check("cpu_reset_latency", 32'(cpu_reset), 32'(!ok));
        @(negedge clk);
    endtask

    task automatic check_status(input bit done, input bit err, input int words);
        check("load_done", 32'(load_done), 32'(done));
        check("load_err", 32'(load_err), 32'(err));
        check("cpu_reset", 32'(cpu_reset), 32'(!done));
        check("words_loaded", 32'(words_loaded), 32'(words));
        check("writes_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  n;
        int  r;
        bit  bad;
        bit  ok;
        wr_t e;

        tbl[0] = '{n: 2, w0: 32'h00000013, w1: 32'h00100093, junk: 0,
                   exp_done: 1, exp_err: 0, exp_words: 2};
        tbl[1] = '{n: 1, w0: 32'hDEADBEEF, w1: 32'h0, junk: 2,
                   exp_done: 1, exp_err: 0, exp_words: 1};
        tbl[2] = '{n: 257, w0: 32'h0, w1: 32'h0, junk: 0,
                   exp_done: 0, exp_err: 1, exp_words: 0};
        tbl[3] = '{n: 0, w0: 32'h0, w1: 32'h0, junk: 1,
                   exp_done: 1, exp_err: 0, exp_words: 0};
        tbl[4] = '{n: 2, w0: 32'h12345678, w1: 32'hCAFEF00D, junk: 0,
                   exp_done: 1, exp_err: 0, exp_words: 2};

        // Reset values, with a MAGIC byte presented during reset that must be ignored.
        repeat (2) @(negedge clk);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            send_junk(tbl[v].junk);
            preset.push_back(tbl[v].w0);
            preset.push_back(tbl[v].w1);
            run_frame(tbl[v].n, 1'b0, 0);
            preset.delete();
            check_status(tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_words);
        end

        // Memory exactly filled; last write lands at the top address.
        run_frame(256, 1'b0, 0);
        check_status(1'b1, 1'b0, 256);
        check("last_addr", 32'(imem_addr), 32'hFF);

        // Reset mid-load, then a clean reload from address 0.
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        reset    = 1'b1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_load_done", 32'(load_done), 32'd0);
        send(8'h03);
        check("midrst_idle", 32'(cpu_reset & ~load_err), 32'd1);
        run_frame(3, 1'b0, 1);
        check_status(1'b1, 1'b0, 3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Hand-built checksum frames: good, then bad, then recovery.
        for (int pass = 0; pass < 2; pass++) begin
            e.addr = '0;
            e.data = 32'h00000013;
            exp_q.push_back(e);
            send(8'hA5); send(8'h01); send(8'h00);
            send(8'h13); send(8'h00); send(8'h00); send(8'h00);
            send(pass == 0 ? 8'h12 : 8'h00);
            @(negedge clk);
            check_status(pass == 0, pass != 0, 1);
        end
        run_frame(1, 1'b0, 0);
        check_status(1'b1, 1'b0, 1);
`endif

        // Random frames against the frame-level model.
        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) n = 0;
            else if (r == 1) n = $urandom_range(257, 600);
            else n = $urandom_range(1, 10);
            bad = $urandom_range(0, 3) == 0;
            send_junk($urandom_range(0, 2));
            run_frame(n, bad, 2);
            ok = (n <= 256) && !(CsumEn && bad);
            check_status(ok, !ok, (n <= 256) ? n : 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
